// File: rtl/integral_image_gen.sv
// Streaming summed-area-table generator.
// Takes 8-bit pixels in raster order and emits ii(x,y) = sum of pix(i,j) for
// all i<=x, j<=y, one word per pixel, with one cycle of latency. A single
// line buffer holds the previous row's integral values, so no frame buffer
// is needed. All sums wrap modulo 2^SUM_W.
module integral_image_gen #(
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 32,
  parameter int MAX_WIDTH = 1024,
  parameter int DIM_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W:0] MAXW = (DIM_W + 1)'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] x_q, y_q;
  logic [SUM_W-1:0] row_sum_q;
  logic [SUM_W-1:0] out_data_q;
  logic             out_valid_q, out_eol_q, out_last_q;
  logic             busy_q, done_q, cfg_err_q;

  // Previous row's integral values, indexed by column. Row 0 never reads it,
  // so contents left over from reset or an earlier frame do not matter.
  logic [SUM_W-1:0] lbuf [MAX_WIDTH];

  logic             accept;
  logic             cfg_ok;
  logic [AW-1:0]    lb_idx;
  logic [SUM_W-1:0] rs_d, above, ii_d;
  logic             at_eol, at_last;

  assign pix_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign cfg_ok    = (cfg_width != '0) && ({1'b0, cfg_width} <= MAXW) &&
                     (cfg_height != '0);
  assign lb_idx    = x_q[AW-1:0];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

  // Datapath for the pixel at (x,y): running row sum plus the value above.
  always_comb begin
    rs_d    = ((x_q == '0) ? '0 : row_sum_q) + SUM_W'(pix_data);
    above   = (y_q == '0) ? '0 : lbuf[lb_idx];
    ii_d    = rs_d + above;
    at_eol  = (x_q == width_q - 1'b1);
    at_last = at_eol && (y_q == height_q - 1'b1);
  end

  // Line buffer write: the new integral value becomes "above" for next row.
  always_ff @(posedge clk) begin
    if (accept) lbuf[lb_idx] <= ii_d;
  end

  // Control FSM with registered outputs, counters and the running row sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_sum_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              width_q   <= cfg_width;
              height_q  <= cfg_height;
              x_q       <= '0;
              y_q       <= '0;
              row_sum_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            out_data_q  <= ii_d;
            out_valid_q <= 1'b1;
            out_eol_q   <= at_eol;
            out_last_q  <= at_last;
            row_sum_q   <= rs_d;
            if (at_eol) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
            if (at_last) state_q <= FLUSH;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        FLUSH: begin
          // Only the final word is left; finish once it drains.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Bench for integral_image_gen: directed frames plus randomized frames and
// handshakes, checked against a direct double-sum reference model.
module tb_integral_image_gen;
  localparam int PIX_W     = 8;
  localparam int SUM_W     = 12;
  localparam int MAX_WIDTH = 16;
  localparam int DIM_W     = 11;
  localparam longint MASK  = (64'd1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [DIM_W-1:0] cfg_width, cfg_height;
  logic             start, pix_valid, pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             out_valid, out_ready;
  logic [SUM_W-1:0] out_data;
  logic             out_eol, out_last, busy, done, cfg_err;

  integral_image_gen #(
    .PIX_W(PIX_W), .SUM_W(SUM_W), .MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_eol(out_eol), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int     px[$];
  longint exp_d[$];
  bit     exp_e[$], exp_l[$];

  // Reference: ii(x,y) as an explicit double sum over the frame.
  task automatic build_model(input int w, input int h);
    exp_d.delete(); exp_e.delete(); exp_l.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        longint s = 0;
        for (int j = 0; j <= y; j++)
          for (int i = 0; i <= x; i++) s += px[j*w + i];
        exp_d.push_back(s & MASK);
        exp_e.push_back(x == w-1);
        exp_l.push_back(x == w-1 && y == h-1);
      end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_pix_ready"}, pix_ready, 0);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_out_data"},  out_data, 0);
    chk({p, "_out_eol"},   out_eol, 0);
    chk({p, "_out_last"},  out_last, 0);
    chk({p, "_busy"},      busy, 0);
    chk({p, "_done"},      done, 0);
    chk({p, "_cfg_err"},   cfg_err, 0);
  endtask

  // mode 0: full throughput; 1: out_ready toggles; 2: random valid/ready.
  // abort_n > 0 returns (mid-cycle, before the edge) once that many pixels
  // are being handed over.
  task automatic run_frame(input int w, input int h, input int mode,
                           input int abort_n);
    int n, k_in, k_out, cyc;
    bit fin, last_out, prev_acc, prev_drain, prev_stall, pe, pl, acc;
    longint pd;
    n = w * h;
    build_model(w, h);
    @(negedge clk);
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); start = 1'b1;
    pix_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k_in = 0; k_out = 0; cyc = 0; fin = 0; last_out = 0;
    prev_acc = 0; prev_drain = 0; prev_stall = 0; pd = 0; pe = 0; pl = 0;
    while (!fin && cyc < 3000) begin
      case (mode)
        0:       begin out_ready = 1'b1; pix_valid = 1'b1; end
        1:       begin out_ready = (cyc % 2 == 0); pix_valid = 1'b1; end
        default: begin
          out_ready = ($urandom_range(0, 3) != 0);
          pix_valid = ($urandom_range(0, 2) != 0);
        end
      endcase
      if (k_in >= n) pix_valid = 1'b0;
      pix_data = (k_in < n) ? PIX_W'(px[k_in]) : PIX_W'($urandom);
      start = (mode == 2 && n >= 4 && cyc == 3);
      cfg_width = start ? '0 : DIM_W'(w);
      #1;
      if (last_out) begin
        chk("done_pulse", done, 1);
        chk("busy_after_done", busy, 0);
        chk("out_valid_after_last", out_valid, 0);
        chk("pix_ready_idle", pix_ready, 0);
        fin = 1;
      end else begin
        chk("done_low", done, 0);
        chk("busy", busy, 1);
        if (mode == 2 && n >= 4 && cyc == 4) chk("start_while_busy", cfg_err, 0);
        if (prev_acc) chk("latency", out_valid, 1);
        else if (prev_drain) chk("drop_valid", out_valid, 0);
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, pd);
          chk("hold_eol", out_eol, pe);
          chk("hold_last", out_last, pl);
        end
        if (out_valid && !out_ready) chk("pix_ready_stall", pix_ready, 0);
        if (k_in >= n) chk("pix_ready_flush", pix_ready, 0);
        if (out_valid && out_ready) begin
          if (k_out < n) begin
            chk("out_data", out_data, exp_d[k_out]);
            chk("out_eol", out_eol, exp_e[k_out]);
            chk("out_last", out_last, exp_l[k_out]);
          end else chk("extra_word", 1, 0);
          k_out++;
          if (k_out == n) last_out = 1;
        end
        acc        = pix_valid && pix_ready;
        prev_acc   = acc;
        prev_drain = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        pd = out_data; pe = out_eol; pl = out_last;
        if (acc) k_in++;
        if (abort_n > 0 && acc && k_in == abort_n) return;
      end
      start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!fin) chk("frame_timeout", 0, 1);
    chk("words_out", k_out, n);
  endtask

  task automatic bad_start(input int w, input int h, input string tag);
    @(negedge clk);
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); start = 1'b1; pix_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_cfg_err"}, cfg_err, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    @(negedge clk);
    #1;
    chk({tag, "_cfg_err_clear"}, cfg_err, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    pix_valid = 1'b0;
  endtask

  task automatic fill(input int n, input int v);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(v);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    cfg_width = '0; cfg_height = '0; pix_data = '0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // pix_valid while idle is ignored
    pix_valid = 1'b1;
    @(negedge clk); #1;
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_busy", busy, 0);
    pix_valid = 1'b0;

    fill(9, 1);   run_frame(3, 3, 0, 0);
    fill(8, 255); run_frame(4, 2, 0, 0);
    px.delete();
    for (int i = 1; i <= 9; i++) px.push_back(i);
    run_frame(3, 3, 1, 0);

    bad_start(0, 3, "w0");
    bad_start(3, 0, "h0");
    bad_start(MAX_WIDTH + 1, 2, "wmax1");

    fill(4, 9); run_frame(2, 2, 0, 0);
    fill(4, 1); run_frame(2, 2, 0, 0);

    // reset after 5 accepted pixels, then a fresh frame
    fill(9, 1); run_frame(3, 3, 0, 5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    pix_valid = 1'b0;
    reset = 1'b1;
    fill(9, 1); run_frame(3, 3, 0, 0);

    // full-width rows and modulo wrap
    fill(MAX_WIDTH * 4, 255); run_frame(MAX_WIDTH, 4, 0, 0);
    px.delete();
    for (int i = 0; i < MAX_WIDTH * 2; i++) px.push_back($urandom_range(0, 255));
    run_frame(MAX_WIDTH, 2, 2, 0);
    fill(1, 200); run_frame(1, 1, 1, 0);

    for (int f = 0; f < 10; f++) begin
      int w, h;
      w = $urandom_range(1, MAX_WIDTH);
      h = $urandom_range(1, 6);
      px.delete();
      for (int i = 0; i < w * h; i++) px.push_back($urandom_range(0, 255));
      run_frame(w, h, $urandom_range(0, 2), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
- Streaming summed-area-table generator that sits directly upstream of each face-detection core.
- Accepts raw 8-bit grayscale pixels in raster order for one core tile and emits integral-image values: ii(x,y) = sum of pix(i,j) over all i<=x, j<=y.
- Output is in the same raster order, one word per pixel, ready to be dumped to the per-core image file and used by the Haar eye/cheek/nose/mouth filters.
- Holds one row of previous integral values internally, so no frame buffer is needed.

Parameters:
PIX_W, 8, input pixel width (unsigned)
SUM_W, 32, integral word width (unsigned, modulo 2^SUM_W)
MAX_WIDTH, 1024, maximum row length in pixels; sizes the line buffer
DIM_W, 11, width of dimension and counter fields (must hold MAX_WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
cfg_width  input  DIM_W  pixels per row; sampled on accepted start
cfg_height  input  DIM_W  rows per frame; sampled on accepted start
start  input  1  single-cycle frame request
pix_valid  input  1  pix_data is valid
pix_ready  output  1  block accepts a pixel this cycle
pix_data  input  PIX_W  unsigned pixel
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  SUM_W  integral value
out_eol  output  1  out_data is last column of a row
out_last  output  1  out_data is final pixel of frame
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion
cfg_err  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset values: pix_ready=0, out_valid=0, out_data=0, out_eol=0, out_last=0, busy=0, done=0, cfg_err=0. State goes to IDLE, and all counters and the row sum clear. Line buffer contents are don't-care.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start with 1<=cfg_width<=MAX_WIDTH and cfg_height>=1: latch dimensions, x=0, y=0, row_sum=0, go to RUN.
  - start with any other configuration: cfg_err=1 for one cycle, stay in IDLE.
- RUN:
  - pix_ready = (!out_valid || out_ready).
  - Accept = pix_valid && pix_ready.
  - On accept:
    - rs = (x==0 ? 0 : row_sum) + pix_data.
    - above = (y==0 ? 0 : lbuf[x]).
    - ii = rs + above, truncated to SUM_W.
    - Register out_data=ii, out_valid=1, out_eol=(x==width-1), out_last=(x==width-1 && y==height-1).
    - Write lbuf[x]=ii, row_sum=rs.
  - Latency is exactly 1 cycle from accept to out_valid.
  - Counter advance: x wraps to 0 at width-1 and y increments then. The accept that produces out_last moves the state to FLUSH.
- Output handshake:
  - An output held with out_valid=1 && !out_ready keeps out_data, out_eol and out_last stable.
  - out_valid drops the cycle after acceptance unless a new pixel is accepted in the same cycle (full throughput: 1 pixel/cycle with out_ready=1).
- FLUSH: pix_ready=0. When the out_last word is accepted: out_valid=0, done=1 for that following cycle, go to IDLE.
- busy=1 in RUN and FLUSH.
- start while busy is ignored and does not raise cfg_err.
- Row 0 never reads lbuf, so stale data from a previous frame or from reset is harmless.
- Arithmetic wraps modulo 2^SUM_W with no saturation. Box-sum differences downstream remain correct under wrap.
- Reset asserted mid-frame: immediate return to reset values. A partial frame is discarded, and the next frame needs a new start.
- pix_valid in IDLE is ignored, since pix_ready=0.

Test Plan:
- 3x3 frame, all pixels 1, out_ready=1 -> out_data 1,2,3,2,4,6,3,6,9 on consecutive cycles; out_eol on the 3rd, 6th and 9th words; out_last on the 9th; done one cycle after the 9th is accepted.
- 4x2 frame, all pixels 255 -> 255,510,765,1020,510,1020,1530,2040; busy high from the cycle after start through done.
- 3x3 frame 1..9 row-major with out_ready toggling 1/0 each cycle -> 1,3,6,5,12,21,12,27,45; out_data stable while stalled; no word lost or duplicated; pix_ready=0 whenever out_valid && !out_ready.
- start with cfg_width=0, then cfg_height=0, then cfg_width=MAX_WIDTH+1 -> cfg_err pulse each time, busy stays 0, pix_ready stays 0.
- Frame A (2x2, all 9) then frame B (2x2, all 1) -> B outputs 1,2,2,4, confirming no line-buffer carry-over between frames.
- Assert reset after 5 accepted pixels of a 3x3 frame -> all outputs return to reset values asynchronously. A new start then reproduces the first scenario's results exactly.
